// File: rtl/c1_share_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// c1_share_arbiter
//
// Shares one external combinational C1 cell among N_REQ requesters. When the
// block is idle, it grants one pending requester in round-robin order. It then
// drives that requester's 8-bit configuration onto the C1 input pins and waits
// SETTLE_CYC cycles. After that it samples c1_f and returns the sampled value
// together with the winner's index.
//
// Ports
//   clk           : clock, all state on the rising edge
//   rst_n         : asynchronous active-low reset
//   req           : per-requester request level
//   cfg           : packed configs, slice i = {S1,S0,SB,B1,B0,SA,A1,A0}
//   ack           : one-cycle one-hot pulse to the served requester
//   result_valid  : one-cycle pulse coincident with ack
//   result_id     : index of the served requester
//   result_f      : sampled C1 output
//   busy          : high while an operation is in SETTLE or DONE
//   c1_*          : registered drive to the C1 inputs
//   c1_f          : C1 output
// -----------------------------------------------------------------------------
module c1_share_arbiter #(
    parameter int N_REQ      = 4,
    parameter int SETTLE_CYC = 1,
    parameter int IDW        = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] cfg,
    output logic [N_REQ-1:0]   ack,
    output logic               result_valid,
    output logic [IDW-1:0]     result_id,
    output logic               result_f,
    output logic               busy,
    output logic               c1_a0,
    output logic               c1_a1,
    output logic               c1_sa,
    output logic               c1_b0,
    output logic               c1_b1,
    output logic               c1_sb,
    output logic               c1_s0,
    output logic               c1_s1,
    input  logic               c1_f
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_e;

    state_e             state_q;
    logic [IDW-1:0]     rr_ptr_q;
    logic [IDW-1:0]     winner_q;
    logic [CNT_W-1:0]   settle_cnt_q;
    logic [7:0]         c1_cfg_q;
    logic [N_REQ-1:0]   ack_q;
    logic               result_valid_q;
    logic [IDW-1:0]     result_id_q;
    logic               result_f_q;
    logic               busy_q;

    logic               pick_valid;
    logic [IDW-1:0]     pick_idx;
    logic [7:0]         pick_cfg;

    // Round-robin search: start at rr_ptr and probe upward, wrapping
    // N_REQ-1 back to 0. The first set request wins.
    always_comb begin
        logic [IDW:0] probe;
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            probe = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (probe >= (IDW+1)'(N_REQ)) begin
                probe = probe - (IDW+1)'(N_REQ);
            end
            if (!pick_valid && req[probe[IDW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = probe[IDW-1:0];
            end
        end
    end

    // Select the winner's configuration slice.
    always_comb begin
        pick_cfg = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (IDW'(k) == pick_idx) begin
                pick_cfg = cfg[8*k +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            winner_q       <= '0;
            settle_cnt_q   <= '0;
            c1_cfg_q       <= '0;
            ack_q          <= '0;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            result_f_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The C1 pins change only here, on the grant edge.
                    if (pick_valid) begin
                        c1_cfg_q     <= pick_cfg;
                        winner_q     <= pick_idx;
                        settle_cnt_q <= CNT_W'(SETTLE_CYC - 1);
                        busy_q       <= 1'b1;
                        state_q      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        result_f_q     <= c1_f;
                        ack_q          <= N_REQ'(1) << winner_q;
                        result_valid_q <= 1'b1;
                        result_id_q    <= winner_q;
                        state_q        <= DONE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    ack_q          <= '0;
                    result_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                    rr_ptr_q       <= (winner_q == IDW'(N_REQ - 1)) ? '0 : winner_q + IDW'(1);
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack          = ack_q;
    assign result_valid = result_valid_q;
    assign result_id    = result_id_q;
    assign result_f     = result_f_q;
    assign busy         = busy_q;

    assign c1_s1 = c1_cfg_q[7];
    assign c1_s0 = c1_cfg_q[6];
    assign c1_sb = c1_cfg_q[5];
    assign c1_b1 = c1_cfg_q[4];
    assign c1_b0 = c1_cfg_q[3];
    assign c1_sa = c1_cfg_q[2];
    assign c1_a1 = c1_cfg_q[1];
    assign c1_a0 = c1_cfg_q[0];

endmodule

// File: tb/tb_c1_share_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_c1_share_arbiter
//
// Self-checking bench for c1_share_arbiter with N_REQ=4 and SETTLE_CYC=1.
// A transaction-level model tracks when the arbiter is free and which
// requester wins. It also tracks the cycle on which the result must appear and
// the C1 function value expected for the captured configuration. A
// combinational C1 model closes the loop on c1_f.
// -----------------------------------------------------------------------------
module tb_c1_share_arbiter;

    localparam int N_REQ      = 4;
    localparam int SETTLE_CYC = 1;
    localparam int IDW        = 2;

    logic               clk;
    logic               rst_n;
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] cfg;
    logic [N_REQ-1:0]   ack;
    logic               result_valid;
    logic [IDW-1:0]     result_id;
    logic               result_f;
    logic               busy;
    logic c1_a0, c1_a1, c1_sa, c1_b0, c1_b1, c1_sb, c1_s0, c1_s1;
    logic               c1_f;
    logic [7:0]         pins;

    c1_share_arbiter #(
        .N_REQ      (N_REQ),
        .SETTLE_CYC (SETTLE_CYC),
        .IDW        (IDW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .cfg          (cfg),
        .ack          (ack),
        .result_valid (result_valid),
        .result_id    (result_id),
        .result_f     (result_f),
        .busy         (busy),
        .c1_a0        (c1_a0),
        .c1_a1        (c1_a1),
        .c1_sa        (c1_sa),
        .c1_b0        (c1_b0),
        .c1_b1        (c1_b1),
        .c1_sb        (c1_sb),
        .c1_s0        (c1_s0),
        .c1_s1        (c1_s1),
        .c1_f         (c1_f)
    );

    // External C1 cell.
    assign c1_f = (c1_s0 | c1_s1) ? (c1_sb ? c1_b1 : c1_b0) : (c1_sa ? c1_a1 : c1_a0);
    assign pins = {c1_s1, c1_s0, c1_sb, c1_b1, c1_b0, c1_sa, c1_a1, c1_a0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // C1 function evaluated from a config byte {S1,S0,SB,B1,B0,SA,A1,A0}.
    function automatic logic c1_ref(input logic [7:0] c);
        logic s, sb, sa;
        s  = c[7] | c[6];
        sb = c[5];
        sa = c[2];
        if (s) return sb ? c[4] : c[3];
        return sa ? c[1] : c[0];
    endfunction

    // ---------------- transaction-level reference model ----------------
    int         cyc;       // index of the last rising edge
    bit         m_act;     // an operation has been granted since reset
    int         m_done;    // edge after which ack/result are visible
    int         m_grant;   // grant edge
    int         m_free;    // first edge on which a new grant may happen
    int         m_w;       // winner
    int         m_ptr;     // round-robin start point
    logic       m_f;
    logic [7:0] m_pins;

    task automatic model_reset();
        m_act  = 1'b0;
        m_ptr  = 0;
        m_free = 0;
        m_pins = '0;
        m_w    = 0;
        m_f    = 1'b0;
    endtask

    task automatic model_edge();
        bit found;
        cyc++;
        if (!rst_n) return;
        if (cyc >= m_free && req != '0) begin
            found = 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                int i;
                i = (m_ptr + k) % N_REQ;
                if (!found && req[i]) begin
                    found = 1'b1;
                    m_w   = i;
                end
            end
            m_pins  = cfg[8*m_w +: 8];
            m_f     = c1_ref(m_pins);
            m_grant = cyc;
            m_done  = cyc + SETTLE_CYC;
            m_free  = cyc + SETTLE_CYC + 2;
            m_ptr   = (m_w + 1) % N_REQ;
            m_act   = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic [N_REQ-1:0] exp_ack;
        logic             exp_busy;
        exp_ack  = (m_act && cyc == m_done) ? (N_REQ'(1) << m_w) : '0;
        exp_busy = m_act && cyc >= m_grant && cyc <= m_done;
        check("ack", 32'(ack), 32'(exp_ack));
        check("result_valid", 32'(result_valid), 32'(exp_ack != '0));
        check("busy", 32'(busy), 32'(exp_busy));
        check("c1_pins", 32'(pins), 32'(m_pins));
        if (exp_ack != '0) begin
            check("result_id", 32'(result_id), 32'(m_w));
            check("result_f", 32'(result_f), 32'(m_f));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rand_cfg();
        for (int k = 0; k < N_REQ; k++) cfg[8*k +: 8] = 8'($urandom);
    endtask

    task automatic idle_steps(input int n);
        req = '0;
        repeat (n) step();
    endtask

    // Called at a negedge: asynchronous reset assertion.
    task automatic async_reset_now();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_valid", 32'(result_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_pins", 32'(pins), 32'h0);
        check("rst_id_f", 32'({result_id, result_f}), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int served[$];

        cyc   = 0;
        rst_n = 1'b0;
        req   = '1;
        rand_cfg();
        model_reset();

        // Reset held with all requests pending: everything stays 0.
        repeat (3) step();
        rst_n = 1'b1;
        step();                         // first edge with rst_n high: grant to 0
        check("first_grant_pins", 32'(pins), 32'(cfg[7:0]));
        req = '0;
        step();
        check("first_grant_id", 32'(result_id), 32'h0);
        idle_steps(3);

        // Single request, cfg 8'hAA -> F = B1 = 0.
        req = 4'b0001;
        cfg[7:0] = 8'hAA;
        step();
        check("aa_pins", 32'(pins), 32'h0000_00AA);
        req = '0;
        step();
        check("aa_ack", 32'(ack), 32'h1);
        check("aa_f", 32'(result_f), 32'h0);
        idle_steps(3);

        // Requester 2, cfg 8'h8E -> F = B0 = 1.
        req = 4'b0100;
        cfg[23:16] = 8'h8E;
        step();
        req = '0;
        step();
        check("8e_ack", 32'(ack), 32'h4);
        check("8e_id", 32'(result_id), 32'h2);
        check("8e_f", 32'(result_f), 32'h1);
        step();
        check("8e_ack_one_cycle", 32'(ack), 32'h0);
        idle_steps(2);

        // Fairness from rr_ptr = 0: all four held high.
        @(negedge clk);
        async_reset_now();
        step();
        rst_n = 1'b1;
        rand_cfg();
        req = '1;
        served.delete();
        repeat (15) begin
            step();
            if (result_valid) served.push_back(int'(result_id));
        end
        check("fair_count", 32'(served.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < served.size()) check("fair_order", 32'(served[i]), 32'(i % N_REQ));
        end
        idle_steps(3);

        // Request withdrawn and cfg scrambled after the grant edge.
        req = 4'b0010;
        cfg[15:8] = 8'h8E;
        step();
        req = '0;
        cfg = '0;
        step();
        check("withdraw_ack", 32'(ack), 32'h2);
        check("withdraw_f", 32'(result_f), 32'h1);
        idle_steps(3);

        // Reset during SETTLE: no ack, pins cleared, re-grant after release.
        rand_cfg();
        req = 4'b0100;
        step();                          // grant, now in SETTLE
        async_reset_now();
        repeat (2) step();
        rst_n = 1'b1;
        step();                          // re-grant
        check("regrant_pins", 32'(pins), 32'(cfg[23:16]));
        req = '0;
        step();
        check("regrant_ack", 32'(ack), 32'h4);
        idle_steps(3);

        // Randomised traffic with occasional asynchronous resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) != 0) req = N_REQ'($urandom) & N_REQ'($urandom | $urandom);
            if ($urandom_range(0, 1) != 0) rand_cfg();
            if ($urandom_range(0, 79) == 0) begin
                async_reset_now();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/c1_share_arbiter.md
# c1_share_arbiter

Round-robin arbiter and sequencer that shares one C1 logic module among N_REQ requesters. Each requester presents an 8-bit C1 configuration and holds a request. The arbiter grants one requester at a time and drives the granted configuration onto the C1 input pins. After a fixed settle interval it samples the C1 output and returns the result with the winner's ID. It sits between the requesting control units and the single combinational C1 instance, which is instantiated outside this block.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- SETTLE_CYC, 1, cycles the C1 inputs are held before sampling (≥1; 0 is illegal)
- IDW, 2, result_id width, equal to clog2(N_REQ) with a minimum of 1

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request level
- cfg  in  8*N_REQ  packed configs; slice i is {S1,S0,SB,B1,B0,SA,A1,A0} for requester i
- ack  out  N_REQ  one-cycle, one-hot pulse to the served requester
- result_valid  out  1  one-cycle pulse, coincident with ack
- result_id  out  IDW  index of the served requester
- result_f  out  1  sampled C1 output
- busy  out  1  high in SETTLE and DONE
- c1_a0, c1_a1, c1_sa, c1_b0, c1_b1, c1_sb, c1_s0, c1_s1  out  1 each  registered drive to the C1 inputs
- c1_f  in  1  C1 output, where F = (S0|S1) ? (SB?B1:B0) : (SA?A1:A0)

## Operation
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - If any req bit is high, pick the first set bit starting from rr_ptr and searching upward, wrapping N_REQ-1 to 0.
  - Latch the winner's cfg slice into the c1_* drive registers and latch the winner index.
  - Load settle_cnt = SETTLE_CYC-1 and go to SETTLE.
  - If no req bit is high, stay in IDLE; the c1_* pins keep their last value.
- SETTLE: if settle_cnt == 0, sample c1_f into result_f and go to DONE; otherwise decrement settle_cnt.
- DONE:
  - ack[winner] = 1, result_valid = 1, result_id = winner for this cycle.
  - Set rr_ptr = winner+1 with wrap, then go to IDLE.
- The configuration is captured at grant. Changes to cfg or req after grant do not affect the operation in flight.
- A requester whose req drops during SETTLE still gets its ack and result pulse.
- A requester that holds req high after its ack is re-arbitrated normally. Round-robin order guarantees every other pending requester is served before it is served again.
- The c1_* pins change only on the grant edge and stay stable through SETTLE and DONE.
- ack, result_valid, result_id, result_f and busy are registered outputs, with no combinational path from req.

## Timing
- Reset values: state = IDLE, rr_ptr = 0, all c1_* = 0, ack = 0, result_valid = 0, result_id = 0, result_f = 0, busy = 0.
- Latency: req is sampled high at edge E0 (grant). The c1_* pins update after E0. c1_f is sampled at edge E0+SETTLE_CYC. ack and result_valid are high between edges E0+SETTLE_CYC and E0+SETTLE_CYC+1.
- Throughput: one operation per SETTLE_CYC+2 cycles. There is no back-to-back grant out of DONE.
- Simultaneous requests are resolved purely by rr_ptr, and exactly one grant is made per IDLE visit.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and all outputs take their reset values. The aborted requester gets no ack.
- Reset released: the first possible grant is on the first rising edge with rst_n high.

## Test plan
- Reset: hold rst_n=0 with req=4'hF, then release → every output stays 0 until the first edge after release; the grant goes to requester 0 (rr_ptr=0).
- Single request, SETTLE_CYC=1: req=4'b0001 with cfg[7:0]=8'hAA, asserted before edge 0 → c1_* = {1,0,1,0,1,0,1,0} (S1..A0) after edge 0; ack=4'b0001, result_valid=1, result_id=0, result_f=0 during the cycle after edge 1.
- Second config: req=4'b0100 with cfg[23:16]=8'h8E → result_id=2, result_f=1, and ack=4'b0100 pulses exactly one cycle.
- Fairness: req=4'hF held continuously → ack pulses in the order 0,1,2,3,0, spaced 3 cycles apart; result_f matches each slice's C1 function.
- Request withdrawn, and cfg changed mid-SETTLE: requester 1 with cfg=8'h8E, then req and cfg changed after the grant edge → ack[1] still pulses with result_f=1.
- Reset mid-operation: drop rst_n during SETTLE → ack stays 0 and the c1_* pins return to 0. After release, the same request is re-granted from rr_ptr=0.
